// File: rtl/single_mips_alu_ctrl_muldiv_if.sv
// rtl/single_mips_alu_ctrl_muldiv_if.sv - decode-side bus of the ALU control / mul-div unit
interface single_mips_alu_ctrl_muldiv_if #(parameter int XLEN = 32);
  logic            VALID;
  logic [1:0]      ALU_OP;
  logic [5:0]      FUNCT;
  logic [XLEN-1:0] SRC_A;
  logic [XLEN-1:0] SRC_B;
  logic [3:0]      ALU_CTRL;
  logic            ILLEGAL;
  logic            STALL;
  logic            MD_BUSY;
  logic            MD_DONE;
  logic [XLEN-1:0] HI;
  logic [XLEN-1:0] LO;
  logic [XLEN-1:0] MD_RESULT;

  modport master (
    output VALID, ALU_OP, FUNCT, SRC_A, SRC_B,
    input  ALU_CTRL, ILLEGAL, STALL, MD_BUSY, MD_DONE, HI, LO, MD_RESULT
  );

  modport slave (
    input  VALID, ALU_OP, FUNCT, SRC_A, SRC_B,
    output ALU_CTRL, ILLEGAL, STALL, MD_BUSY, MD_DONE, HI, LO, MD_RESULT
  );
endinterface

// File: rtl/single_mips_alu_ctrl_muldiv.sv
// rtl/single_mips_alu_ctrl_muldiv.sv - ALU control decode with iterative mult/div engine and HI/LO
// The engine is built only when MIPS_MULDIV_EN is defined; otherwise MD-class functs decode as illegal.
module single_mips_alu_ctrl_muldiv #(parameter int XLEN = 32) (
  input logic CLK,
  input logic RST,
  single_mips_alu_ctrl_muldiv_if.slave bus
);
`ifdef MIPS_MULDIV_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif
  localparam logic [5:0] F_MFHI = 6'b010000;
  localparam logic [5:0] F_MTHI = 6'b010001;
  localparam logic [5:0] F_MFLO = 6'b010010;
  localparam logic [5:0] F_MTLO = 6'b010011;

  logic       r_type, md_funct, r_known;
  logic [3:0] r_ctrl;

  assign r_type   = bus.ALU_OP == 2'b10;
  assign md_funct = (bus.FUNCT[5:2] == 4'b0100) || (bus.FUNCT[5:2] == 4'b0110);

  always_comb begin
    r_ctrl  = 4'b1111;
    r_known = 1'b1;
    case (bus.FUNCT)
      6'b100000, 6'b100001: r_ctrl = 4'b0010;
      6'b100010, 6'b100011: r_ctrl = 4'b0110;
      6'b100100:            r_ctrl = 4'b0000;
      6'b100101:            r_ctrl = 4'b0001;
      6'b100110:            r_ctrl = 4'b0011;
      6'b100111:            r_ctrl = 4'b0100;
      6'b101010:            r_ctrl = 4'b0111;
      6'b101011:            r_ctrl = 4'b0101;
      6'b000000:            r_ctrl = 4'b1000;
      6'b000010:            r_ctrl = 4'b1001;
      6'b000011:            r_ctrl = 4'b1010;
      default:              r_known = 1'b0;
    endcase
  end

  assign bus.ALU_CTRL = (bus.ALU_OP == 2'b00) ? 4'b0010 : (bus.ALU_OP[0] ? 4'b0110 : r_ctrl);
  assign bus.ILLEGAL  = bus.VALID && r_type && !(r_known || (MD_EN && md_funct));

`ifdef MIPS_MULDIV_EN
  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, FIXUP} state_t;
  state_t state, state_nx;

  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] acc, prod;
  logic [XLEN-1:0]   opnd, a_raw, hi_q, lo_q, a_abs, b_abs, quo, rem;
  logic [XLEN:0]     mul_sum, div_trial;
  logic              is_div, neg_res, neg_rem, div_zero, div_ovf, done_q;
  logic              accept, start, sgn, a_neg, b_neg;

  assign accept = bus.VALID && r_type && md_funct && (state == IDLE);
  assign start  = accept && bus.FUNCT[3];
  assign sgn    = !bus.FUNCT[0];
  assign a_neg  = sgn && bus.SRC_A[XLEN-1];
  assign b_neg  = sgn && bus.SRC_B[XLEN-1];
  assign a_abs  = a_neg ? -bus.SRC_A : bus.SRC_A;
  assign b_abs  = b_neg ? -bus.SRC_B : bus.SRC_B;

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (cnt == CW'(XLEN-1)) state_nx = FIXUP;
      FIXUP:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // acc holds {partial, multiplier} for mult and {remainder, dividend/quotient} for div
  assign mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
  assign div_trial = acc[2*XLEN-1:XLEN-1] - {1'b0, opnd};
  assign prod      = neg_res ? -acc : acc;
  assign quo       = neg_res ? -acc[XLEN-1:0] : acc[XLEN-1:0];
  assign rem       = neg_rem ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt <= '0; acc <= '0; opnd <= '0; a_raw <= '0; hi_q <= '0; lo_q <= '0;
      is_div <= 1'b0; neg_res <= 1'b0; neg_rem <= 1'b0;
      div_zero <= 1'b0; div_ovf <= 1'b0; done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept && bus.FUNCT == F_MTHI) hi_q <= bus.SRC_A;
          if (accept && bus.FUNCT == F_MTLO) lo_q <= bus.SRC_A;
          if (start) begin
            is_div   <= bus.FUNCT[1];
            neg_res  <= a_neg ^ b_neg;
            neg_rem  <= a_neg;
            a_raw    <= bus.SRC_A;
            div_zero <= bus.SRC_B == '0;
            div_ovf  <= sgn && bus.SRC_A == XMIN && bus.SRC_B == '1;
            cnt      <= '0;
            opnd     <= bus.FUNCT[1] ? b_abs : a_abs;
            acc      <= {{XLEN{1'b0}}, bus.FUNCT[1] ? a_abs : b_abs};
          end
        end
        RUN: begin
          cnt <= cnt + CW'(1);
          if (is_div)
            acc <= {div_trial[XLEN] ? acc[2*XLEN-2:XLEN-1] : div_trial[XLEN-1:0],
                    acc[XLEN-2:0], ~div_trial[XLEN]};
          else
            acc <= {mul_sum, acc[XLEN-1:1]};
        end
        FIXUP: begin
          done_q <= 1'b1;
          if (!is_div) begin
            {hi_q, lo_q} <= prod;
          end else if (div_zero) begin
            hi_q <= a_raw;
            lo_q <= '1;
          end else if (div_ovf) begin
            hi_q <= '0;
            lo_q <= XMIN;
          end else begin
            hi_q <= rem;
            lo_q <= quo;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.MD_BUSY   = state != IDLE;
  assign bus.MD_DONE   = done_q;
  assign bus.HI        = hi_q;
  assign bus.LO        = lo_q;
  assign bus.STALL     = bus.VALID && r_type && md_funct && (state != IDLE);
  assign bus.MD_RESULT = (bus.VALID && r_type && bus.FUNCT == F_MFHI) ? hi_q :
                         (bus.VALID && r_type && bus.FUNCT == F_MFLO) ? lo_q : '0;
`else
  logic unused_inputs;
  assign unused_inputs = ^{CLK, RST, bus.SRC_A, bus.SRC_B, F_MFHI, F_MTHI, F_MFLO, F_MTLO};
  assign bus.MD_BUSY   = 1'b0;
  assign bus.MD_DONE   = 1'b0;
  assign bus.HI        = '0;
  assign bus.LO        = '0;
  assign bus.STALL     = 1'b0;
  assign bus.MD_RESULT = '0;
`endif
endmodule

// File: tb/tb_single_mips_alu_ctrl_muldiv.sv
// tb/tb_single_mips_alu_ctrl_muldiv.sv - scoreboard bench for the ALU control and mul/div unit
module tb_single_mips_alu_ctrl_muldiv;
  localparam int XLEN = 32;
`ifdef MIPS_MULDIV_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif
  localparam logic [5:0] MFHI = 6'b010000, MTHI = 6'b010001, MFLO = 6'b010010, MTLO = 6'b010011;
  localparam logic [5:0] MULT = 6'b011000, MULTU = 6'b011001, DIV = 6'b011010, DIVU = 6'b011011;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  single_mips_alu_ctrl_muldiv_if #(.XLEN(XLEN)) bus ();
  single_mips_alu_ctrl_muldiv #(.XLEN(XLEN)) dut (.CLK(CLK), .RST(RST), .bus(bus));

  typedef struct {
    logic [3:0] ctrl;
    logic illegal, stall, busy, done;
    logic [31:0] hi, lo, res;
  } obs_t;
  typedef struct {
    logic [31:0] hi, lo;
    int edge_n;
  } md_t;

  obs_t obs_q[$];
  md_t  md_q[$];
  obs_t mon_e;
  md_t  mon_m;
  int n_checks = 0;
  int n_fail = 0;
  int edge_n = 0;

  // reference state: architectural HI/LO plus a countdown of busy cycles
  logic [31:0] m_hi, m_lo;
  logic [63:0] pend;
  int busy_left;
  bit done_f;

  logic [5:0] flist [24] = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100, 6'b100101,
                             6'b100110, 6'b100111, 6'b101010, 6'b101011, 6'b000000, 6'b000010,
                             6'b000011, MFHI, MTHI, MFLO, MTLO, MULT, MULTU, DIV, DIVU,
                             MULT, DIV, 6'b111111};

  always @(posedge CLK) edge_n <= edge_n + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] exp_ctrl(input logic [1:0] op, input logic [5:0] f);
    if (op == 2'b00) return 4'b0010;
    if (op[0]) return 4'b0110;
    case (f)
      6'b100000, 6'b100001: return 4'b0010;
      6'b100010, 6'b100011: return 4'b0110;
      6'b100100: return 4'b0000;
      6'b100101: return 4'b0001;
      6'b100110: return 4'b0011;
      6'b100111: return 4'b0100;
      6'b101010: return 4'b0111;
      6'b101011: return 4'b0101;
      6'b000000: return 4'b1000;
      6'b000010: return 4'b1001;
      6'b000011: return 4'b1010;
      default:   return 4'b1111;
    endcase
  endfunction

  function automatic bit is_md(input logic [5:0] f);
    return f inside {MFHI, MTHI, MFLO, MTLO, MULT, MULTU, DIV, DIVU};
  endfunction

  function automatic logic [63:0] md_ref(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sp;
    logic [63:0] up;
    int q, r;
    if (f == MULT) begin
      sp = longint'($signed(a)) * longint'($signed(b));
      return 64'(sp);
    end
    if (f == MULTU) begin
      up = {32'b0, a} * {32'b0, b};
      return up;
    end
    if (b == 32'h0) return {a, 32'hFFFFFFFF};
    if (f == DIV) begin
      if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
      return {r, q};
    end
    return {a % b, a / b};
  endfunction

  task automatic step(input bit r, input bit v, input logic [1:0] op, input logic [5:0] f,
                      input logic [31:0] a, input logic [31:0] b);
    obs_t e;
    md_t m;
    bit acc, rtype;
    RST = r; bus.VALID = v; bus.ALU_OP = op; bus.FUNCT = f; bus.SRC_A = a; bus.SRC_B = b;
    rtype = v && op == 2'b10;
    e.ctrl    = exp_ctrl(op, f);
    e.illegal = rtype && exp_ctrl(2'b10, f) == 4'b1111 && f != 6'b100000 && !(MD_EN && is_md(f));
    e.stall   = MD_EN && rtype && is_md(f) && busy_left > 0;
    e.busy    = busy_left > 0;
    e.done    = done_f;
    e.hi      = m_hi;
    e.lo      = m_lo;
    e.res     = (MD_EN && rtype && f == MFHI) ? m_hi : (MD_EN && rtype && f == MFLO) ? m_lo : 32'h0;
    obs_q.push_back(e);
    @(posedge CLK); #1;
    if (r) begin
      m_hi = 0; m_lo = 0; busy_left = 0; done_f = 0;
      md_q.delete();
    end else begin
      acc = MD_EN && rtype && is_md(f) && busy_left == 0;
      done_f = 0;
      if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) begin
          m_hi = pend[63:32];
          m_lo = pend[31:0];
          done_f = 1;
        end
      end
      if (acc) begin
        if (f == MTHI) m_hi = a;
        else if (f == MTLO) m_lo = a;
        else if (f[3]) begin
          pend = md_ref(f, a, b);
          busy_left = XLEN + 1;
          m.hi = pend[63:32];
          m.lo = pend[31:0];
          m.edge_n = edge_n + XLEN + 1;
          md_q.push_back(m);
        end
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 2'b00, 6'h00, 32'h0, 32'h0);
  endtask

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  always @(negedge CLK) begin
    if (obs_q.size() > 0) begin
      mon_e = obs_q.pop_front();
      check("alu_ctrl",  64'(bus.ALU_CTRL),  64'(mon_e.ctrl));
      check("illegal",   64'(bus.ILLEGAL),   64'(mon_e.illegal));
      check("stall",     64'(bus.STALL),     64'(mon_e.stall));
      check("md_busy",   64'(bus.MD_BUSY),   64'(mon_e.busy));
      check("md_done",   64'(bus.MD_DONE),   64'(mon_e.done));
      check("hi",        64'(bus.HI),        64'(mon_e.hi));
      check("lo",        64'(bus.LO),        64'(mon_e.lo));
      check("md_result", 64'(bus.MD_RESULT), 64'(mon_e.res));
    end
    if (bus.MD_DONE === 1'b1) begin
      if (md_q.size() == 0) begin
        check("md_done_spurious", 64'(bus.MD_DONE), 64'(0));
      end else begin
        mon_m = md_q.pop_front();
        check("done_hi",   64'(bus.HI), 64'(mon_m.hi));
        check("done_lo",   64'(bus.LO), 64'(mon_m.lo));
        check("done_edge", 64'(edge_n), 64'(mon_m.edge_n));
      end
    end
  end

  initial begin
    logic [1:0] op;
    logic [5:0] f;
    RST = 1'b1; bus.VALID = 1'b0; bus.ALU_OP = 2'b00; bus.FUNCT = 6'h00;
    bus.SRC_A = 32'h0; bus.SRC_B = 32'h0;
    m_hi = 0; m_lo = 0; pend = 0; busy_left = 0; done_f = 0;
    repeat (2) @(posedge CLK);
    #1;
    idle(2);
    step(1'b0, 1'b1, 2'b10, 6'b100111, 32'h0, 32'h0);
    step(1'b0, 1'b1, 2'b10, 6'b000011, 32'h0, 32'h0);
    step(1'b0, 1'b1, 2'b10, 6'b111111, 32'h0, 32'h0);
    step(1'b0, 1'b1, 2'b11, 6'b100100, 32'h0, 32'h0);
    step(1'b0, 1'b1, 2'b10, MULT, 32'hFFFFFFFD, 32'h5);
    idle(36);
    step(1'b0, 1'b1, 2'b10, DIV, 32'hFFFFFFF9, 32'h2);
    idle(35);
    step(1'b0, 1'b1, 2'b10, DIVU, 32'h7, 32'h2);
    idle(35);
    step(1'b0, 1'b1, 2'b10, DIV, 32'h9, 32'h0);
    idle(35);
    step(1'b0, 1'b1, 2'b10, DIV, 32'h80000000, 32'hFFFFFFFF);
    idle(35);
    step(1'b0, 1'b1, 2'b10, MULTU, 32'h12345678, 32'h9ABCDEF0);
    repeat (35) step(1'b0, 1'b1, 2'b10, MFLO, 32'h0, 32'h0);
    step(1'b0, 1'b1, 2'b10, MTHI, 32'h1234, 32'h0);
    step(1'b0, 1'b1, 2'b10, MFHI, 32'h0, 32'h0);
    idle(2);
    step(1'b0, 1'b1, 2'b10, DIV, 32'h7FFF0001, 32'h3);
    idle(9);
    step(1'b1, 1'b0, 2'b00, 6'h00, 32'h0, 32'h0);
    idle(40);
    for (int k = 0; k < 2500; k++) begin
      op = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b10;
      f  = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63)) : flist[$urandom_range(0, 23)];
      step($urandom_range(0, 299) == 0, $urandom_range(0, 7) != 0, op, f, rand_opnd(), rand_opnd());
    end
    idle(40);
    check("md_done_missing", 64'(md_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
